perceptron_mac: RTL and testbench



---
 rtl/perceptron_mac_pkg.sv | 23 ++
 rtl/perceptron_mac_if.sv | 40 ++++
 rtl/perceptron_mac_product.sv | 16 +
 rtl/perceptron_mac.sv | 125 ++++++++++++
 tb/tb_perceptron_mac.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/perceptron_mac_pkg.sv
// Shared types and defaults for the perceptron MAC stage.
// Saturation helpers are used only when PERCEPTRON_MAC_SAT_EN is defined.
package perceptron_pkg;

  localparam int unsigned DATA_W_DEF = 6;
  localparam int unsigned ACC_W_DEF  = 14;
  localparam int unsigned NUM_IN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  function automatic longint signed sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint signed sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/perceptron_mac_if.sv
// Handshake bundle between the perceptron MAC, its feeder and the threshold stage.
// The ovf flag is present only when PERCEPTRON_MAC_SAT_EN is defined.
interface perceptron_mac_if
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
);
  logic                     start;
  logic signed [DATA_W-1:0] bias;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] w_in;
  logic signed [ACC_W-1:0]  sum_out;
  logic                     sum_valid;
  logic                     sum_ready;
  logic                     busy;
`ifdef PERCEPTRON_MAC_SAT_EN
  logic                     ovf;

  modport master (
    output start, bias, in_valid, x_in, w_in, sum_ready,
    input  in_ready, sum_out, sum_valid, busy, ovf
  );
  modport slave (
    input  start, bias, in_valid, x_in, w_in, sum_ready,
    output in_ready, sum_out, sum_valid, busy, ovf
  );
`else
  modport master (
    output start, bias, in_valid, x_in, w_in, sum_ready,
    input  in_ready, sum_out, sum_valid, busy
  );
  modport slave (
    input  start, bias, in_valid, x_in, w_in, sum_ready,
    output in_ready, sum_out, sum_valid, busy
  );
`endif
endinterface

// File: rtl/perceptron_mac_product.sv
// Combinational signed DATA_W x DATA_W multiply, sign-extended to ACC_W.
module mac_product
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  p_o
);
  logic signed [2*DATA_W-1:0] p_full;

  assign p_full = a_i * b_i;
  assign p_o    = ACC_W'(p_full);
endmodule

// File: rtl/perceptron_mac.sv
// Sequential multiply-accumulate: bias + sum of NUM_IN x*w products over valid/ready.
// Define PERCEPTRON_MAC_SAT_EN for saturating adds and the sticky ovf flag.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned NUM_IN = NUM_IN_DEF
) (
  input logic             clk,
  input logic             rst,
  perceptron_mac_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(NUM_IN + 1);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("perceptron_mac: ACC_W must be >= 2*DATA_W");
  end
  if (NUM_IN < 1) begin : g_bad_num_in
    $error("perceptron_mac: NUM_IN must be >= 1");
  end

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc_add;
  logic [ACC_W:0]           acc_wide;
  logic                     beat;

  mac_product #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac_product (
    .a_i(bus.x_in),
    .b_i(bus.w_in),
    .p_o(prod)
  );

  // One guard bit: the top two bits disagree exactly when the signed add overflows.
  assign acc_wide = {acc_q[ACC_W-1], acc_q} + {prod[ACC_W-1], prod};

`ifdef PERCEPTRON_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic ovf_q, ovf_d;
  logic sat_hit;

  assign sat_hit = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
  assign acc_add = !sat_hit ? acc_wide[ACC_W-1:0]
                 : (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX);
  assign bus.ovf = ovf_q;
`else
  assign acc_add = acc_wide[ACC_W-1:0];
`endif

  assign beat = (state_q == ACCUM) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
`ifdef PERCEPTRON_MAC_SAT_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = ACC_W'(bus.bias);
          cnt_d   = '0;
`ifdef PERCEPTRON_MAC_SAT_EN
          ovf_d   = 1'b0;
`endif
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_add;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef PERCEPTRON_MAC_SAT_EN
          ovf_d = ovf_q | sat_hit;
`endif
          // Result register loads with the final beat so sum_out is ready on DONE entry.
          if (cnt_q == CNT_W'(NUM_IN - 1)) begin
            sum_d   = acc_add;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
`ifdef PERCEPTRON_MAC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
`ifdef PERCEPTRON_MAC_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.sum_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_perceptron_mac.sv
// Directed bench for perceptron_mac: default build plus an ACC_W=12 overflow instance.
// Expectations for the overflow case follow PERCEPTRON_MAC_SAT_EN.
module tb_perceptron_mac;
  import perceptron_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  perceptron_mac_if #(.DATA_W(6), .ACC_W(14)) bus_a ();
  perceptron_mac_if #(.DATA_W(6), .ACC_W(12)) bus_b ();

  perceptron_mac #(.DATA_W(6), .ACC_W(14), .NUM_IN(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  perceptron_mac #(.DATA_W(6), .ACC_W(12), .NUM_IN(2)) dut_w12 (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input int b);
    bus_a.bias  = 6'(b);
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic beat_a(input int x, input int w);
    bus_a.in_valid = 1'b1;
    bus_a.x_in     = 6'(x);
    bus_a.w_in     = 6'(w);
    tick();
    bus_a.in_valid = 1'b0;
  endtask

  int vb[3]   = '{0, -32, 31};
  int vx0[3]  = '{2, 31, -32};
  int vw0[3]  = '{3, 31, 31};
  int vx1[3]  = '{-4, -32, 0};
  int vw1[3]  = '{5, -32, 5};
  int vexp[3] = '{-14, 1953, -961};

  initial begin
    int prev_cyc;
    bus_a.start = 1'b0; bus_a.bias = '0; bus_a.in_valid = 1'b0;
    bus_a.x_in = '0; bus_a.w_in = '0; bus_a.sum_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.bias = '0; bus_b.in_valid = 1'b0;
    bus_b.x_in = '0; bus_b.w_in = '0; bus_b.sum_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", bus_a.busy, 0);
    check("rst_in_ready", bus_a.in_ready, 0);
    check("rst_sum_valid", bus_a.sum_valid, 0);
    check("rst_sum_out", bus_a.sum_out, 0);
`ifdef PERCEPTRON_MAC_SAT_EN
    check("rst_ovf", bus_a.ovf, 0);
`endif
    rst = 1'b0;

    // basic evaluation: 5 + 3*4 + (-2)*7 = 3
    bus_a.sum_ready = 1'b1;
    start_a(5);
    check("t1_busy", bus_a.busy, 1);
    check("t1_in_ready", bus_a.in_ready, 1);
    beat_a(3, 4);
    check("t1_no_early_valid", bus_a.sum_valid, 0);
    beat_a(-2, 7);
    check("t1_latency_valid", bus_a.sum_valid, 1);
    check("t1_sum", bus_a.sum_out, 3);
    check("t1_in_ready_done", bus_a.in_ready, 0);
    tick();
    check("t1_valid_pulse", bus_a.sum_valid, 0);
    check("t1_idle", bus_a.busy, 0);

    // gaps between beats
    start_a(5);
    beat_a(3, 4);
    repeat (3) begin
      tick();
      check("t2_gap_acc", dut.acc_q, 17);
      check("t2_gap_in_ready", bus_a.in_ready, 1);
      check("t2_gap_valid", bus_a.sum_valid, 0);
    end
    beat_a(-2, 7);
    check("t2_valid", bus_a.sum_valid, 1);
    check("t2_sum", bus_a.sum_out, 3);
    tick();

    // backpressure in DONE, start ignored
    bus_a.sum_ready = 1'b0;
    start_a(5);
    beat_a(3, 4);
    beat_a(-2, 7);
    bus_a.start = 1'b1;
    bus_a.bias  = 6'(9);
    repeat (5) begin
      check("t3_hold_valid", bus_a.sum_valid, 1);
      check("t3_hold_sum", bus_a.sum_out, 3);
      check("t3_hold_in_ready", bus_a.in_ready, 0);
      tick();
    end
    bus_a.start = 1'b0;
    bus_a.sum_ready = 1'b1;
    tick();
    check("t3_release_idle", bus_a.busy, 0);
    check("t3_release_valid", bus_a.sum_valid, 0);
    tick();
    check("t3_start_not_queued", bus_a.busy, 0);

    // overflow on the ACC_W=12 instance: 1024 + 1024
    bus_b.sum_ready = 1'b1;
    bus_b.bias  = '0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start    = 1'b0;
    bus_b.in_valid = 1'b1;
    bus_b.x_in     = 6'(-32);
    bus_b.w_in     = 6'(-32);
    tick();
    tick();
    bus_b.in_valid = 1'b0;
    check("t4_valid", bus_b.sum_valid, 1);
`ifdef PERCEPTRON_MAC_SAT_EN
    check("t4_sum_sat", bus_b.sum_out, 2047);
    check("t4_ovf", bus_b.ovf, 1);
`else
    check("t4_sum_wrap", bus_b.sum_out, -2048);
`endif
    tick();

    // reset mid-ACCUM, then a fresh evaluation: -1 + 1 + 1 = 1
    start_a(7);
    beat_a(1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", bus_a.busy, 0);
    check("t5_in_ready", bus_a.in_ready, 0);
    check("t5_valid", bus_a.sum_valid, 0);
    check("t5_sum_cleared", bus_a.sum_out, 0);
    start_a(-1);
    beat_a(1, 1);
    beat_a(1, 1);
    check("t5_valid_after", bus_a.sum_valid, 1);
    check("t5_sum", bus_a.sum_out, 1);
    tick();

    // back-to-back with start held high
    bus_a.sum_ready = 1'b1;
    bus_a.start     = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      bus_a.bias = 6'(vb[i]);
      tick();
      check("t6_accum", bus_a.in_ready, 1);
      beat_a(vx0[i], vw0[i]);
      beat_a(vx1[i], vw1[i]);
      check("t6_valid", bus_a.sum_valid, 1);
      check("t6_sum", bus_a.sum_out, vexp[i]);
      if (i > 0) check("t6_period", cyc - prev_cyc, 4);
      prev_cyc = cyc;
      tick();
      check("t6_idle", bus_a.busy, 0);
    end
    bus_a.start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
